// File: rtl/irrig_pkg.sv
// Shared definitions for the irrigation valve controller: state encoding,
// parameter defaults and the phase-counter width.
package irrig_pkg;

    localparam int unsigned CNT_W = 32;

    localparam int unsigned DEBOUNCE_CYC_DEF  = 500_000;
    localparam int unsigned SETTLE_CYC_DEF    = 25_000_000;
    localparam int unsigned MAX_WATER_CYC_DEF = 1_500_000_000;
    localparam int unsigned LOCKOUT_CYC_DEF   = 250_000_000;

    localparam logic [2:0] ST_CLOSED   = 3'd0;
    localparam logic [2:0] ST_OPENING  = 3'd1;
    localparam logic [2:0] ST_WATERING = 3'd2;
    localparam logic [2:0] ST_CLOSING  = 3'd3;
    localparam logic [2:0] ST_LOCKOUT  = 3'd4;

    typedef enum logic [2:0] {
        S_CLOSED   = ST_CLOSED,
        S_OPENING  = ST_OPENING,
        S_WATERING = ST_WATERING,
        S_CLOSING  = ST_CLOSING,
        S_LOCKOUT  = ST_LOCKOUT
    } irrig_state_e;

    // Terminal count for a duration parameter; a duration of 0 behaves as 1.
    function automatic logic [CNT_W-1:0] last_cnt(input int unsigned cycles);
        return (cycles == 0) ? '0 : CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/rain_debounce.sv
// Rain sensor input conditioning: 2-flop synchronizer followed by a debouncer
// that accepts a new level only after it has been stable for DEBOUNCE_CYC cycles.
module rain_debounce
    import irrig_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic rain_raw_i,
    output logic rain_db_o
);

    localparam logic [CNT_W-1:0] DB_LAST = last_cnt(DEBOUNCE_CYC);

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == DB_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= rain_raw_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rain_db_o = db_q;

endmodule

// File: rtl/irrigation_ctrl.sv
// Irrigation valve sequencer driving a servo open/closed with settle, timeout
// and lockout timing. Define IRRIG_STATS_EN to count completed watering sessions.
module irrigation_ctrl
    import irrig_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
    parameter int unsigned SETTLE_CYC    = SETTLE_CYC_DEF,
    parameter int unsigned MAX_WATER_CYC = MAX_WATER_CYC_DEF,
    parameter int unsigned LOCKOUT_CYC   = LOCKOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rain_raw,
    input  logic        dry_req,
    input  logic        manual_req,
    output logic        angle_sel,
    output logic        valve_open,
    output logic        busy,
    output logic        timeout,
    output logic        rain_db,
    output logic [15:0] water_cnt
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = last_cnt(SETTLE_CYC);
    localparam logic [CNT_W-1:0] WATER_LAST  = last_cnt(MAX_WATER_CYC);
    localparam logic [CNT_W-1:0] LOCK_LAST   = last_cnt(LOCKOUT_CYC);

    irrig_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             angle_q, angle_d;
    logic             timeout_q, timeout_d;
    logic             lock_q, lock_d;
    logic             req;
    logic             water_hit;

    rain_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_rain_db (
        .clk       (clk),
        .reset     (reset),
        .rain_raw_i(rain_raw),
        .rain_db_o (rain_db)
    );

    assign req       = dry_req | manual_req;
    assign water_hit = (cnt_q == WATER_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 32'd1;
        timeout_d = timeout_q;
        lock_d    = lock_q;
        case (state_q)
            S_CLOSED: begin
                cnt_d = '0;
                if (req && !rain_db) begin
                    state_d   = S_OPENING;
                    timeout_d = 1'b0;
                    lock_d    = 1'b0;
                end
            end
            S_OPENING: begin
                if (rain_db) begin
                    state_d = S_CLOSING;
                    lock_d  = 1'b1;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_WATERING;
                end
            end
            S_WATERING: begin
                // All close causes seen in one cycle are recorded together.
                if (rain_db || !req || water_hit) begin
                    state_d = S_CLOSING;
                    lock_d  = rain_db | water_hit;
                    if (water_hit) timeout_d = 1'b1;
                end
            end
            S_CLOSING: begin
                if (cnt_q == SETTLE_LAST) state_d = lock_q ? S_LOCKOUT : S_CLOSED;
            end
            S_LOCKOUT: begin
                if (cnt_q == LOCK_LAST) state_d = S_CLOSED;
            end
            default: state_d = S_CLOSED;
        endcase
        if (state_d != state_q) cnt_d = '0;
        // Registered from the next state so the servo command never glitches.
        angle_d = !((state_d == S_OPENING) || (state_d == S_WATERING));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_CLOSED;
            cnt_q     <= '0;
            angle_q   <= 1'b1;
            timeout_q <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            angle_q   <= angle_d;
            timeout_q <= timeout_d;
            lock_q    <= lock_d;
        end
    end

    assign angle_sel  = angle_q;
    assign valve_open = (state_q == S_WATERING);
    assign busy       = (state_q == S_OPENING) || (state_q == S_CLOSING) ||
                        (state_q == S_LOCKOUT);
    assign timeout    = timeout_q;

`ifdef IRRIG_STATS_EN
    logic [15:0] wcnt_q;
    logic        session_done;

    assign session_done = (state_q == S_WATERING) && (state_d == S_CLOSING);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q <= '0;
        end else if (session_done && (wcnt_q != 16'hFFFF)) begin
            wcnt_q <= wcnt_q + 16'd1;
        end
    end

    assign water_cnt = wcnt_q;
`else
    assign water_cnt = '0;
`endif

endmodule

// File: tb/tb_irrigation_ctrl.sv
// Self-checking bench for irrigation_ctrl: timestamp-based reference model
// compared every cycle, directed scenarios with literal timing, random traffic.
module tb_irrigation_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned S  = 10;
    localparam int unsigned MW = 50;
    localparam int unsigned L  = 20;

    localparam int P_CLOSED   = 0;
    localparam int P_OPENING  = 1;
    localparam int P_WATERING = 2;
    localparam int P_CLOSING  = 3;
    localparam int P_LOCKOUT  = 4;

    logic        clk = 1'b0;
    logic        reset, rain_raw, dry_req, manual_req;
    logic        angle_sel, valve_open, busy, timeout, rain_db;
    logic [15:0] water_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    irrigation_ctrl #(
        .DEBOUNCE_CYC (DB),
        .SETTLE_CYC   (S),
        .MAX_WATER_CYC(MW),
        .LOCKOUT_CYC  (L)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rain_raw  (rain_raw),
        .dry_req   (dry_req),
        .manual_req(manual_req),
        .angle_sel (angle_sel),
        .valve_open(valve_open),
        .busy      (busy),
        .timeout   (timeout),
        .rain_db   (rain_db),
        .water_cnt (water_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phases with absolute entry timestamps, rain via sample history.
    int  cyc = 0;
    int  m_ph;
    int  m_start;
    bit  m_to, m_lock, m_db, m_s1, m_s2;
    bit  hist[$];
    int  m_wcnt;
    bit  m_req, m_hit, m_all;

    always @(posedge clk) begin
        if (reset) begin
            m_ph = P_CLOSED; m_start = cyc; m_to = 0; m_lock = 0;
            m_db = 0; m_s1 = 0; m_s2 = 0; hist.delete(); m_wcnt = 0;
        end else begin
            m_req = dry_req | manual_req;
            case (m_ph)
                P_CLOSED:
                    if (m_req && !m_db) begin
                        m_ph = P_OPENING; m_start = cyc; m_to = 0; m_lock = 0;
                    end
                P_OPENING:
                    if (m_db) begin
                        m_ph = P_CLOSING; m_start = cyc; m_lock = 1;
                    end else if (cyc - m_start == int'(S)) begin
                        m_ph = P_WATERING; m_start = cyc;
                    end
                P_WATERING: begin
                    m_hit = (cyc - m_start == int'(MW));
                    if (m_db || !m_req || m_hit) begin
                        m_ph = P_CLOSING; m_start = cyc;
                        m_lock = m_db | m_hit;
                        if (m_hit) m_to = 1;
                        if (m_wcnt < 65535) m_wcnt++;
                    end
                end
                P_CLOSING:
                    if (cyc - m_start == int'(S)) begin
                        m_ph = m_lock ? P_LOCKOUT : P_CLOSED; m_start = cyc;
                    end
                default:
                    if (cyc - m_start == int'(L)) begin
                        m_ph = P_CLOSED; m_start = cyc;
                    end
            endcase
            hist.push_back(m_s2);
            if (hist.size() > DB) void'(hist.pop_front());
            if (hist.size() == DB) begin
                m_all = 1;
                foreach (hist[i]) if (hist[i] == m_db) m_all = 0;
                if (m_all) begin
                    m_db = !m_db;
                    hist.delete();
                end
            end
            m_s2 = m_s1;
            m_s1 = rain_raw;
        end
        cyc++;
    end

    always @(posedge clk) begin
        #1;
        check("model_angle_sel", {31'd0, angle_sel},
              {31'd0, !(m_ph == P_OPENING || m_ph == P_WATERING)});
        check("model_valve_open", {31'd0, valve_open}, {31'd0, m_ph == P_WATERING});
        check("model_busy", {31'd0, busy},
              {31'd0, m_ph == P_OPENING || m_ph == P_CLOSING || m_ph == P_LOCKOUT});
        check("model_timeout", {31'd0, timeout}, {31'd0, m_to});
        check("model_rain_db", {31'd0, rain_db}, {31'd0, m_db});
`ifdef IRRIG_STATS_EN
        check("model_water_cnt", {16'd0, water_cnt}, m_wcnt);
`else
        check("model_water_cnt", {16'd0, water_cnt}, 32'd0);
`endif
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic cur(input int sel);
        case (sel)
            0: return angle_sel;
            1: return valve_open;
            2: return busy;
            3: return timeout;
            default: return rain_db;
        endcase
    endfunction

    // Counts falling edges until the selected output reaches val (bounded).
    task automatic wait_for(input int sel, input logic val, input int maxc, output int k);
        k = 0;
        while (cur(sel) !== val && k < maxc) begin
            @(negedge clk);
            k++;
        end
    endtask

    localparam int SA = 0, SV = 1, SB = 2, ST = 3, SR = 4;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset = 1; rain_raw = 0; dry_req = 0; manual_req = 0;
        tick(3);
        check("rst_angle", {31'd0, angle_sel}, 1);
        check("rst_valve", {31'd0, valve_open}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_timeout", {31'd0, timeout}, 0);
        check("rst_rain_db", {31'd0, rain_db}, 0);
        check("rst_water_cnt", {16'd0, water_cnt}, 0);
        reset = 0;
        tick(2);

        // Normal session ended by request drop.
        dry_req = 1;
        tick(1);
        check("open_angle_next_cycle", {31'd0, angle_sel}, 0);
        wait_for(SV, 1, 30, k);
        check("settle_latency", k, 10);
        dry_req = 0;
        tick(1);
        check("drop_closes", {31'd0, valve_open}, 0);
        wait_for(SB, 0, 40, k);
        check("close_no_lockout", k, 10);

        // Timeout, lockout, automatic re-open.
        tick(3);
        dry_req = 1;
        tick(1);
        wait_for(ST, 1, 100, k);
        check("timeout_latency", k, 60);
        wait_for(SA, 0, 60, k);
        check("reopen_after_lockout", k, 31);
        check("timeout_clears", {31'd0, timeout}, 0);
        dry_req = 0;
        wait_for(SV, 1, 20, k);
        check("opening_not_aborted", k, 10);
        tick(1);
        check("entry_eval_closes", {31'd0, valve_open}, 0);
        wait_for(SB, 0, 40, k);
        check("entry_close_no_lockout", k, 10);

        // Rain debouncing.
        rain_raw = 1; tick(3); rain_raw = 0;
        tick(10);
        check("short_pulse_ignored", {31'd0, rain_db}, 0);
        rain_raw = 1; tick(5);
        check("rain_db_not_yet", {31'd0, rain_db}, 0);
        tick(1);
        check("rain_db_latency", {31'd0, rain_db}, 1);
        rain_raw = 0;
        tick(8);
        check("rain_db_falls", {31'd0, rain_db}, 0);

        // Rain during watering.
        dry_req = 1;
        wait_for(SV, 1, 30, k);
        tick(5);
        rain_raw = 1;
        wait_for(SR, 1, 10, k);
        check("rain_in_watering_latency", k, 6);
        check("valve_before_rain_close", {31'd0, valve_open}, 1);
        rain_raw = 0; dry_req = 0;
        tick(1);
        check("rain_close", {31'd0, valve_open}, 0);
        wait_for(SB, 0, 60, k);
        check("rain_lockout_len", k, 30);
        check("rain_no_timeout", {31'd0, timeout}, 0);

        // Rain during OPENING, manual request ignored in LOCKOUT.
        tick(10);
        dry_req = 1; rain_raw = 1;
        tick(6);
        check("opening_before_rain", {31'd0, angle_sel}, 0);
        tick(1);
        check("opening_rain_abort", {31'd0, angle_sel}, 1);
        rain_raw = 0; dry_req = 0; manual_req = 1;
        tick(20);
        check("lockout_ignores_manual", {31'd0, angle_sel}, 1);
        wait_for(SA, 0, 40, k);
        check("manual_after_lockout", k, 11);
        manual_req = 0;
        wait_for(SV, 1, 30, k);
        tick(1);
        wait_for(SB, 0, 40, k);

        // Asynchronous reset in WATERING.
        dry_req = 1;
        wait_for(SV, 1, 30, k);
        tick(3);
        reset = 1;
        #1;
        check("async_reset_angle", {31'd0, angle_sel}, 1);
        check("async_reset_valve", {31'd0, valve_open}, 0);
        tick(2);
        reset = 0; dry_req = 0;
        tick(2);
        check("no_lockout_after_reset", {31'd0, busy}, 0);

        // Three sessions for the statistics counter.
        for (int s = 0; s < 3; s++) begin
            manual_req = 1;
            wait_for(SV, 1, 30, k);
            manual_req = 0;
            tick(1);
            wait_for(SB, 0, 40, k);
        end
`ifdef IRRIG_STATS_EN
        check("three_sessions", {16'd0, water_cnt}, 3);
`else
        check("three_sessions", {16'd0, water_cnt}, 0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(39) == 0) dry_req = ~dry_req;
            if ($urandom_range(59) == 0) manual_req = ~manual_req;
            if ($urandom_range(11) == 0) rain_raw = ~rain_raw;
        end
        dry_req = 0; manual_req = 0; rain_raw = 0;
        tick(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
